// File: rtl/pc_fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches 1/2-word instructions and hands them over.
// Define PC_RETURN_STACK_EN to build the internal return-address stack for CALL/RET.
module pc_fetch_seq #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic [ADDR_WIDTH-1:0]              imem_addr,
    output logic                               imem_en,
    input  logic [2*DATA_WIDTH-1:0]            imem_rdata,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [2:0]                         cmd_op,
    input  logic                               err_clr,
    output logic                               instr_valid,
    output logic [DATA_WIDTH-1:0]              instr_opcode,
    output logic [DATA_WIDTH-1:0]              instr_arg,
    output logic [ADDR_WIDTH-1:0]              instr_target,
    output logic [ADDR_WIDTH-1:0]              instr_pc,
    output logic                               instr_long,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_err
);

    localparam int unsigned LvlW = $clog2(STACK_DEPTH + 1);
    localparam logic [2:0] OpJump   = 3'b001;
    localparam logic [2:0] OpBranch = 3'b010;
    localparam logic [2:0] OpCall   = 3'b011;
    localparam logic [2:0] OpRet    = 3'b100;

    typedef enum logic [1:0] {StF1, StC1, StC2, StVld} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, target_q, target_d, pc_len;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d, arg_q, arg_d;
    logic                  long_q, long_d, valid_q, valid_d, err_q, err_d;
    logic                  new_err, rdata_long;

`ifdef PC_RETURN_STACK_EN
    localparam int unsigned IdxW = $clog2(STACK_DEPTH);
    logic [LvlW-1:0]       level_q, level_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];
    assign stack_level = level_q;
`else
    assign stack_level = '0;
`endif

    assign rdata_long = imem_rdata[2*DATA_WIDTH-1];
    assign pc_len     = pc_q + (long_q ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));

    // Word 1 is requested in C1 as soon as word 0 shows the instruction is long.
    assign imem_en   = !reset && (state_q == StF1 || (state_q == StC1 && rdata_long));
    assign imem_addr = (state_q == StC1 && rdata_long) ? pc_q + ADDR_WIDTH'(1) : pc_q;

    assign instr_valid  = valid_q;
    assign cmd_ready    = valid_q;
    assign instr_opcode = opcode_q;
    assign instr_arg    = arg_q;
    assign instr_target = target_q;
    assign instr_pc     = pc_q;
    assign instr_long   = long_q;
    assign stack_err    = err_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        arg_d    = arg_q;
        target_d = target_q;
        long_d   = long_q;
        new_err  = 1'b0;
`ifdef PC_RETURN_STACK_EN
        level_d  = level_q;
        stack_d  = stack_q;
`endif
        unique case (state_q)
            StF1: state_d = StC1;
            StC1: begin
                opcode_d = imem_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                arg_d    = imem_rdata[DATA_WIDTH-1:0];
                long_d   = rdata_long;
                target_d = ADDR_WIDTH'(imem_rdata[DATA_WIDTH-1:0]);
                state_d  = rdata_long ? StC2 : StVld;
            end
            StC2: begin
                target_d = imem_rdata[ADDR_WIDTH-1:0];
                state_d  = StVld;
            end
            StVld: begin
                if (cmd_valid) begin
                    state_d = StF1;
                    pc_d    = pc_len;
                    case (cmd_op)
                        OpJump:   pc_d = target_q;
                        OpBranch: pc_d = pc_q + target_q;
                        OpCall: begin
                            pc_d = target_q;
`ifdef PC_RETURN_STACK_EN
                            if (level_q < LvlW'(STACK_DEPTH)) begin
                                stack_d[IdxW'(level_q)] = pc_len;
                                level_d = level_q + LvlW'(1);
                            end else begin
                                new_err = 1'b1;
                            end
`endif
                        end
                        OpRet: begin
`ifdef PC_RETURN_STACK_EN
                            if (level_q != '0) begin
                                pc_d    = stack_q[IdxW'(level_q - LvlW'(1))];
                                level_d = level_q - LvlW'(1);
                            end else begin
                                pc_d    = RESET_PC;
                                new_err = 1'b1;
                            end
`else
                            pc_d    = RESET_PC;
                            new_err = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = StF1;
        endcase
        // A fresh error beats a simultaneous clear.
        err_d   = (err_q && !err_clr) || new_err;
        valid_d = (state_d == StVld);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StF1;
            pc_q     <= RESET_PC;
            opcode_q <= '0;
            arg_q    <= '0;
            target_q <= '0;
            long_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef PC_RETURN_STACK_EN
            level_q  <= '0;
            stack_q  <= '{default: '0};
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            arg_q    <= arg_d;
            target_q <= target_d;
            long_q   <= long_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
`ifdef PC_RETURN_STACK_EN
            level_q  <= level_d;
            stack_q  <= stack_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: table of commands with expected next PC, stack level and error flag,
// checked through an expectation queue, plus hand-written reset sequences.
module tb_pc_fetch_seq;

    localparam logic [2:0] OpNext   = 3'b000;
    localparam logic [2:0] OpJump   = 3'b001;
    localparam logic [2:0] OpBranch = 3'b010;
    localparam logic [2:0] OpCall   = 3'b011;
    localparam logic [2:0] OpRet    = 3'b100;
`ifdef PC_RETURN_STACK_EN
    localparam logic [3:0] CallLvl = 4'd1;
`else
    localparam logic [3:0] CallLvl = 4'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] imem_addr;
    logic        imem_en;
    logic [15:0] imem_rdata = 16'h0;
    logic        cmd_valid, cmd_ready, err_clr;
    logic [2:0]  cmd_op;
    logic        instr_valid, instr_long, stack_err;
    logic [7:0]  instr_opcode, instr_arg;
    logic [11:0] instr_target, instr_pc;
    logic [3:0]  stack_level;

    logic [15:0] mem [4096];

    typedef struct {
        logic [2:0]  op;
        logic        clr;
        logic        pre_clr;
        logic [11:0] pc;
        logic [3:0]  lvl;
        logic        err;
    } vec_t;

    typedef struct {
        logic [11:0] pc;
        logic [7:0]  opc;
        logic [7:0]  arg;
        logic [11:0] tgt;
        logic        lng;
        logic [3:0]  lvl;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    pc_fetch_seq dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .err_clr      (err_clr),
        .instr_valid  (instr_valid),
        .instr_opcode (instr_opcode),
        .instr_arg    (instr_arg),
        .instr_target (instr_target),
        .instr_pc     (instr_pc),
        .instr_long   (instr_long),
        .stack_level  (stack_level),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t row(input logic [2:0] op, input logic clr, input logic pre,
                                 input logic [11:0] pc, input logic [3:0] lvl, input logic err);
        vec_t v;
        v.op = op; v.clr = clr; v.pre_clr = pre; v.pc = pc; v.lvl = lvl; v.err = err;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [11:0] pc, input logic [3:0] lvl, input logic err);
        exp_t e;
        logic [15:0] w0, w1;
        w0 = mem[pc];
        w1 = mem[pc + 12'd1];
        e.pc  = pc;
        e.opc = w0[15:8];
        e.arg = w0[7:0];
        e.lng = w0[15];
        e.tgt = e.lng ? w1[11:0] : {4'h0, w0[7:0]};
        e.lvl = lvl;
        e.err = err;
        e.lat = e.lng ? 4 : 3;
        return e;
    endfunction

    task automatic compare_sb(input string tag, input int lat);
        exp_t e;
        e = sb.pop_front();
        check({tag, " valid"},   32'(instr_valid), 32'd1);
        check({tag, " ready"},   32'(cmd_ready), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " pc"},      32'(instr_pc), 32'(e.pc));
        check({tag, " opcode"},  32'(instr_opcode), 32'(e.opc));
        check({tag, " arg"},     32'(instr_arg), 32'(e.arg));
        check({tag, " target"},  32'(instr_target), 32'(e.tgt));
        check({tag, " long"},    32'(instr_long), 32'(e.lng));
        check({tag, " level"},   32'(stack_level), 32'(e.lvl));
        check({tag, " err"},     32'(stack_err), 32'(e.err));
        check({tag, " imem_en"}, 32'(imem_en), 32'd0);
    endtask

    // Called at a falling edge; holds reset one cycle and checks the refetch from address 0.
    task automatic reset_check(input string tag);
        exp_t e;
        int   lat;
        reset = 1'b1;
        #1;
        check({tag, " rst valid"},  32'(instr_valid), 32'd0);
        check({tag, " rst ready"},  32'(cmd_ready), 32'd0);
        check({tag, " rst pc"},     32'(instr_pc), 32'd0);
        check({tag, " rst opcode"}, 32'(instr_opcode), 32'd0);
        check({tag, " rst arg"},    32'(instr_arg), 32'd0);
        check({tag, " rst target"}, 32'(instr_target), 32'd0);
        check({tag, " rst long"},   32'(instr_long), 32'd0);
        check({tag, " rst level"},  32'(stack_level), 32'd0);
        check({tag, " rst err"},    32'(stack_err), 32'd0);
        check({tag, " rst imem_en"}, 32'(imem_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, " f1 imem_en"},   32'(imem_en), 32'd1);
        check({tag, " f1 imem_addr"}, 32'(imem_addr), 32'd0);
        e = mk_exp(12'h000, 4'd0, 1'b0);
        e.lat = e.lng ? 3 : 2;
        sb.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, " c1 imem_en"}, 32'(imem_en), 32'd0);
        end while (!instr_valid && lat < 12);
        compare_sb({tag, " first"}, lat);
    endtask

    task automatic apply_row(input vec_t v, input int idx);
        string tag;
        int    lat;
        tag = $sformatf("row%0d", idx);
        if (v.pre_clr) begin
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            check({tag, " err_clr"}, 32'(stack_err), 32'd0);
        end
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        err_clr   = v.clr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        sb.push_back(mk_exp(v.pc, v.lvl, v.err));
        @(negedge clk);
        check({tag, " valid drop"}, 32'(instr_valid), 32'd0);
        lat = 1;
        while (!instr_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        compare_sb(tag, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished",
                 $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h000] = 16'h0105;
        mem[12'h001] = 16'h8500; mem[12'h002] = 16'h0040;
        mem[12'h005] = 16'h8100; mem[12'h006] = 16'h0010;
        mem[12'h010] = 16'h8133; mem[12'h011] = 16'h0234;
        mem[12'h012] = 16'h8200; mem[12'h013] = 16'h0020;
        mem[12'h01E] = 16'h8400; mem[12'h01F] = 16'h0FFF;
        mem[12'h020] = 16'h8300; mem[12'h021] = 16'h0FFE;
        mem[12'h040] = 16'h06A0;
        mem[12'h041] = 16'h01B0;
        mem[12'h0A0] = 16'h07B0;
        for (int i = 0; i < 9; i++) mem[12'h0B0 + 12'(i)] = {8'h06, 8'hB1 + 8'(i)};
        mem[12'h0B9] = 16'h0900;
        mem[12'hFFF] = 16'h0102;

        vecs.push_back(row(OpJump,   1'b0, 1'b0, 12'h005, 4'd0, 1'b0));
        vecs.push_back(row(OpJump,   1'b0, 1'b0, 12'h010, 4'd0, 1'b0));
        vecs.push_back(row(OpNext,   1'b0, 1'b0, 12'h012, 4'd0, 1'b0));
        vecs.push_back(row(OpJump,   1'b0, 1'b0, 12'h020, 4'd0, 1'b0));
        vecs.push_back(row(OpBranch, 1'b0, 1'b0, 12'h01E, 4'd0, 1'b0));
        vecs.push_back(row(OpJump,   1'b0, 1'b0, 12'hFFF, 4'd0, 1'b0));
        vecs.push_back(row(OpBranch, 1'b0, 1'b0, 12'h001, 4'd0, 1'b0));
        vecs.push_back(row(OpJump,   1'b0, 1'b0, 12'h040, 4'd0, 1'b0));
        vecs.push_back(row(OpCall,   1'b0, 1'b0, 12'h0A0, CallLvl, 1'b0));
`ifdef PC_RETURN_STACK_EN
        vecs.push_back(row(OpRet,    1'b0, 1'b0, 12'h041, 4'd0, 1'b0));
        vecs.push_back(row(OpJump,   1'b0, 1'b0, 12'h0B0, 4'd0, 1'b0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(row(OpCall, i == 8, 1'b0, 12'h0B1 + 12'(i),
                               4'((i < 8) ? i + 1 : 8), i == 8));
        for (int k = 0; k < 8; k++)
            vecs.push_back(row(OpRet, 1'b0, k == 0, 12'h0B8 - 12'(k), 4'(7 - k), 1'b0));
        vecs.push_back(row(OpRet,    1'b0, 1'b0, 12'h000, 4'd0, 1'b1));
`else
        vecs.push_back(row(OpRet,    1'b0, 1'b0, 12'h000, 4'd0, 1'b1));
        vecs.push_back(row(OpNext,   1'b1, 1'b0, 12'h001, 4'd0, 1'b0));
        vecs.push_back(row(OpJump,   1'b0, 1'b0, 12'h040, 4'd0, 1'b0));
        vecs.push_back(row(OpCall,   1'b0, 1'b0, 12'h0A0, 4'd0, 1'b0));
        vecs.push_back(row(OpJump,   1'b0, 1'b0, 12'h0B0, 4'd0, 1'b0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(row(OpCall, i == 8, 1'b0, 12'h0B1 + 12'(i), 4'd0, 1'b0));
        vecs.push_back(row(OpRet,    1'b0, 1'b1, 12'h000, 4'd0, 1'b1));
`endif
        vecs.push_back(row(OpJump,   1'b1, 1'b0, 12'h005, 4'd0, 1'b0));

        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        reset_check("por");

        foreach (vecs[i]) apply_row(vecs[i], i);

        // CALL from the long instruction at 0x005, then reset while word 1 is being captured.
        cmd_valid = 1'b1;
        cmd_op    = OpCall;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("c1 word1 imem_en",   32'(imem_en), 32'd1);
        check("c1 word1 imem_addr", 32'(imem_addr), 32'h011);
        @(negedge clk);
        check("c2 opcode latched", 32'(instr_opcode), 32'h81);
        check("c2 stack level",    32'(stack_level), 32'(CallLvl));
        reset_check("c2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
